netwalk_rule_prog_ctrl: RTL and testbench
=========================================

# netwalk_rule_prog_ctrl

Rule-programming sequencer for the NetWalk dataplane lookup table. It drains 128-bit command words from a host-side first-word-fall-through command FIFO, assembles complete rules (match data, mask, exec action), waits for the dataplane to report idle, then issues single-cycle program or delete strobes on the dataplane programming port. It also tracks a 64-entry valid bitmap and provides a bulk clear-all sequence.

## Interface
- N_ENTRIES, 64, table depth; the address width is 6.
- DATA_W, 356, match data/mask width.
- EXEC_W, 372, exec action width.

Ports:
- dpl_clk  in  1  single clock.
- dpl_reset_n  in  1  reset, asynchronous, active-low.
- cmd_data_i  in  128  head word of the FWFT command FIFO.
- cmd_empty_i  in  1  FIFO empty.
- cmd_rd_o  out  1  pop; combinational, asserted only when cmd_empty_i=0.
- dpl_idle_i  in  1  dataplane has no packet in flight.
- dpl_hold_o  out  1  asks ingress to stop admitting packets; registered.
- dpl_program_addr  out  6  table address; registered.
- dpl_program_data  out  356  match data; registered.
- dpl_program_mask  out  356  match mask; registered.
- dpl_exec_data  out  372  exec action; registered.
- dpl_program_enable  out  1  one-cycle write strobe.
- dpl_delete_enable  out  1  one-cycle invalidate strobe.
- busy_o  out  1  high whenever the FSM is not in IDLE.
- err_o  out  1  sticky flag for an unknown opcode.
- err_clr_i  in  1  clears err_o.
- valid_o  out  64  per-entry valid bitmap.

## Operation
- Header word format:
  - [127:120] is the opcode: 0x00 NOP, 0x01 WRITE, 0x02 DELETE, 0x03 CLEAR_ALL.
  - [5:0] is the address.
  - All other bits are ignored.
- WRITE is the header followed by 9 payload words:
  - Words 1–3 form data, with word k going to bits [128(k-1)+127 : 128(k-1)].
  - Words 4–6 form mask, using the same mapping.
  - Words 7–9 form exec, using the same mapping.
  - Bits above the field width are discarded.
- DELETE and CLEAR_ALL are header-only commands.
- FSM states: IDLE, COLLECT, WAIT_IDLE, COMMIT, CLEAR.
- IDLE:
  - If cmd_empty_i=0, pop the header.
  - NOP: stay in IDLE.
  - WRITE: latch the address, clear the word counter, go to COLLECT.
  - DELETE: latch the address, go to WAIT_IDLE.
  - CLEAR_ALL: clear the address counter, go to WAIT_IDLE.
  - Any other opcode: set err_o and stay in IDLE. The word is consumed.
- COLLECT:
  - Pop one word per cycle while cmd_empty_i=0 and store it at slot = counter. Counter runs 0..8.
  - When cmd_empty_i=1, stall with no timeout.
  - After storing slot 8, go to WAIT_IDLE.
- WAIT_IDLE:
  - dpl_hold_o=1 in this state.
  - Stay here until dpl_idle_i=1.
  - Then go to COMMIT for WRITE/DELETE, or to CLEAR for CLEAR_ALL.
- COMMIT (one cycle):
  - WRITE: dpl_program_enable=1 and valid_o[addr] is set.
  - DELETE: dpl_delete_enable=1 and valid_o[addr] is cleared.
  - Return to IDLE.
- CLEAR:
  - dpl_delete_enable=1 each cycle, with dpl_program_addr equal to the counter, for 0..63.
  - valid_o is zeroed on the last cycle.
  - Return to IDLE.
  - dpl_idle_i is not rechecked during CLEAR.
- dpl_hold_o is high in WAIT_IDLE, COMMIT and CLEAR.
- WRITE to an address that is already valid overwrites it; the valid bit stays 1.
- When err_o set and err_clr_i occur in the same cycle, set wins.
- No command is popped while the FSM is outside IDLE/COLLECT.

## Timing
- Reset: every output is 0, including valid_o=0, err_o=0 and all bus outputs. The FSM goes to IDLE. Any partially assembled rule is discarded. Reset may assert mid-sequence and aborts immediately.
- WRITE with the FIFO pre-filled and dpl_idle_i=1:
  - Header popped in cycle 0, payload in cycles 1–9.
  - WAIT_IDLE in cycle 10.
  - dpl_program_enable high in cycle 11 only.
  - busy_o falls in cycle 12.
- DELETE: header in cycle 0, WAIT_IDLE in cycle 1, delete strobe in cycle 2.
- CLEAR_ALL: delete strobes in cycles 2..65, with addresses 0..63 in order.
- Address, data, mask and exec are stable in the strobe cycle. They hold their last values afterwards.
- Strobes are never asserted while dpl_idle_i=0 at entry, and never together.

## Test plan
- WRITE, addr 5: payload words 0x…01..0x…09, dpl_idle_i=1 → program_enable one pulse at cycle 11, addr=5, data[127:0]=word1, exec[371:256]=word9[115:0], valid_o=64'h20.
- Empty gaps: FIFO empty for 3 cycles after payload word 4 → no pop while empty, correct assembly, strobe at cycle 14.
- dpl_idle_i=0 held for 20 cycles after collection → dpl_hold_o=1 throughout, no strobe until idle rises, then the strobe occurs the next cycle.
- DELETE addr 5 after the write → delete_enable one pulse at addr 5, valid_o=0. Follow with CLEAR_ALL → 64 consecutive delete pulses, addresses 0..63.
- Opcode 0x7F → word popped, err_o=1, no strobe. Then err_clr_i → err_o=0. Set and clear in the same cycle → err_o stays 1.
- Reset asserted at payload word 6 → all outputs 0. A subsequent full WRITE to addr 2 programs correctly with no residue.

Source files
------------

// File: rtl/netwalk_rule_prog_ctrl_if.sv
// Command-FIFO, dataplane-programming and status signals of the rule-programming sequencer.
// master = the sequencer, slave = the host/dataplane environment.
interface netwalk_rule_prog_ctrl_if;
  // cmd_rd_o pops the FWFT head word; it is only ever high while cmd_empty_i=0, and the
  // word on cmd_data_i is consumed at the rising edge where cmd_rd_o=1.
  logic [127:0] cmd_data_i;
  logic         cmd_empty_i;
  logic         cmd_rd_o;
  logic         dpl_idle_i;
  logic         dpl_hold_o;
  logic [5:0]   dpl_program_addr;
  logic [355:0] dpl_program_data;
  logic [355:0] dpl_program_mask;
  logic [371:0] dpl_exec_data;
  logic         dpl_program_enable;
  logic         dpl_delete_enable;
  logic         busy_o;
  logic         err_o;
  logic         err_clr_i;
  logic [63:0]  valid_o;
  logic [2:0]   fsm_state;

  modport master (
    input  cmd_data_i, cmd_empty_i, dpl_idle_i, err_clr_i,
    output cmd_rd_o, dpl_hold_o, dpl_program_addr, dpl_program_data, dpl_program_mask,
           dpl_exec_data, dpl_program_enable, dpl_delete_enable, busy_o, err_o, valid_o,
           fsm_state
  );

  modport slave (
    output cmd_data_i, cmd_empty_i, dpl_idle_i, err_clr_i,
    input  cmd_rd_o, dpl_hold_o, dpl_program_addr, dpl_program_data, dpl_program_mask,
           dpl_exec_data, dpl_program_enable, dpl_delete_enable, busy_o, err_o, valid_o,
           fsm_state
  );
endinterface

// File: rtl/netwalk_rule_prog_ctrl.sv
// Drains command words, assembles WRITE rules, waits for dataplane idle, then issues
// program/delete strobes and maintains the 64-entry valid bitmap.
module netwalk_rule_prog_ctrl (
  input  logic                            dpl_clk,
  input  logic                            dpl_reset_n,
  netwalk_rule_prog_ctrl_if.master        bus
);

  typedef enum logic [2:0] {IDLE, COLLECT, WAIT_IDLE, COMMIT, CLEAR} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_WRITE, OP_DELETE, OP_CLEAR} op_t;

  state_t       state;
  op_t          op_q;
  logic [3:0]   cnt;
  logic [5:0]   addr_q;
  logic [355:0] data_buf;
  logic [355:0] mask_buf;
  logic [371:0] exec_buf;
  logic [7:0]   opcode;
  logic         err_set;

  assign opcode         = bus.cmd_data_i[127:120];
  assign bus.cmd_rd_o   = dpl_reset_n && !bus.cmd_empty_i &&
                          ((state == IDLE) || (state == COLLECT));
  assign err_set        = (state == IDLE) && !bus.cmd_empty_i && (opcode > 8'h03);
  assign bus.busy_o     = (state != IDLE);
  assign bus.fsm_state  = state;

  always_ff @(posedge dpl_clk or negedge dpl_reset_n) begin
    if (!dpl_reset_n) begin
      state                  <= IDLE;
      op_q                   <= OP_NONE;
      cnt                    <= '0;
      addr_q                 <= '0;
      data_buf               <= '0;
      mask_buf               <= '0;
      exec_buf               <= '0;
      bus.dpl_hold_o         <= 1'b0;
      bus.dpl_program_addr   <= '0;
      bus.dpl_program_data   <= '0;
      bus.dpl_program_mask   <= '0;
      bus.dpl_exec_data      <= '0;
      bus.dpl_program_enable <= 1'b0;
      bus.dpl_delete_enable  <= 1'b0;
      bus.err_o              <= 1'b0;
      bus.valid_o            <= '0;
    end else begin
      bus.dpl_program_enable <= 1'b0;
      bus.dpl_delete_enable  <= 1'b0;
      bus.err_o              <= err_set | (bus.err_o & ~bus.err_clr_i);
      case (state)
        IDLE: begin
          if (!bus.cmd_empty_i) begin
            case (opcode)
              8'h01: begin
                addr_q <= bus.cmd_data_i[5:0];
                op_q   <= OP_WRITE;
                cnt    <= '0;
                state  <= COLLECT;
              end
              8'h02: begin
                addr_q         <= bus.cmd_data_i[5:0];
                op_q           <= OP_DELETE;
                bus.dpl_hold_o <= 1'b1;
                state          <= WAIT_IDLE;
              end
              8'h03: begin
                addr_q         <= '0;
                op_q           <= OP_CLEAR;
                bus.dpl_hold_o <= 1'b1;
                state          <= WAIT_IDLE;
              end
              default: ;
            endcase
          end
        end
        COLLECT: begin
          if (!bus.cmd_empty_i) begin
            // Slots 2, 5 and 8 carry only the low bits that fit each field.
            case (cnt)
              4'd0:    data_buf[127:0]   <= bus.cmd_data_i;
              4'd1:    data_buf[255:128] <= bus.cmd_data_i;
              4'd2:    data_buf[355:256] <= bus.cmd_data_i[99:0];
              4'd3:    mask_buf[127:0]   <= bus.cmd_data_i;
              4'd4:    mask_buf[255:128] <= bus.cmd_data_i;
              4'd5:    mask_buf[355:256] <= bus.cmd_data_i[99:0];
              4'd6:    exec_buf[127:0]   <= bus.cmd_data_i;
              4'd7:    exec_buf[255:128] <= bus.cmd_data_i;
              default: exec_buf[371:256] <= bus.cmd_data_i[115:0];
            endcase
            if (cnt == 4'd8) begin
              bus.dpl_hold_o <= 1'b1;
              state          <= WAIT_IDLE;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        WAIT_IDLE: begin
          if (bus.dpl_idle_i) begin
            bus.dpl_program_addr <= addr_q;
            if (op_q == OP_CLEAR) begin
              bus.dpl_delete_enable <= 1'b1;
              state                 <= CLEAR;
            end else if (op_q == OP_WRITE) begin
              bus.dpl_program_data    <= data_buf;
              bus.dpl_program_mask    <= mask_buf;
              bus.dpl_exec_data       <= exec_buf;
              bus.dpl_program_enable  <= 1'b1;
              bus.valid_o[addr_q]     <= 1'b1;
              state                   <= COMMIT;
            end else begin
              bus.dpl_delete_enable   <= 1'b1;
              bus.valid_o[addr_q]     <= 1'b0;
              state                   <= COMMIT;
            end
          end
        end
        COMMIT: begin
          bus.dpl_hold_o <= 1'b0;
          state          <= IDLE;
        end
        CLEAR: begin
          // The strobe for the current address is already on the port; advance or finish.
          if (addr_q == 6'd63) begin
            bus.valid_o    <= '0;
            bus.dpl_hold_o <= 1'b0;
            state          <= IDLE;
          end else begin
            addr_q                <= addr_q + 6'd1;
            bus.dpl_program_addr  <= addr_q + 6'd1;
            bus.dpl_delete_enable <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_netwalk_rule_prog_ctrl.sv
// Directed bench for netwalk_rule_prog_ctrl: FWFT FIFO model, expected-strobe queue
// checked by a negedge monitor, and status checks after each command.
module tb_netwalk_rule_prog_ctrl;

  typedef struct packed {
    logic         del;
    logic [5:0]   addr;
    logic [31:0]  cyc;
    logic [355:0] data;
    logic [355:0] mask;
    logic [371:0] exec;
  } exp_t;

  logic         dpl_clk;
  logic         dpl_reset_n;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [127:0] fifo[$];
  exp_t         exp_q[$];
  logic [63:0]  valid_exp = '0;

  netwalk_rule_prog_ctrl_if bus();

  netwalk_rule_prog_ctrl dut (
    .dpl_clk     (dpl_clk),
    .dpl_reset_n (dpl_reset_n),
    .bus         (bus)
  );

  // clock / reset
  initial dpl_clk = 1'b0;
  always #5 dpl_clk = ~dpl_clk;
  always @(posedge dpl_clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // driver tasks
  function automatic void refresh();
    bus.cmd_empty_i = (fifo.size() == 0);
    bus.cmd_data_i  = (fifo.size() == 0) ? 128'h0 : fifo[0];
  endfunction

  task automatic step();
    logic rd;
    @(negedge dpl_clk);
    rd = bus.cmd_rd_o;
    @(posedge dpl_clk);
    #1;
    if (rd) void'(fifo.pop_front());
    refresh();
  endtask

  task automatic wait_done(input int start, input int exp_fall, input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.busy_o && n < 300);
    chk({tag, "_done"}, 512'(bus.busy_o), 512'(0));
    chk({tag, "_busy_fall_cycle"}, 512'(cyc - start), 512'(exp_fall));
    chk({tag, "_hold_released"}, 512'(bus.dpl_hold_o), 512'(0));
  endtask

  task automatic do_write(input logic [5:0] a, input int gap, input int idle_low);
    logic [127:0] w[10];
    logic [127:0] r;
    exp_t e;
    int start;
    r = {$urandom, $urandom, $urandom, $urandom};
    w[0] = {8'h01, r[119:6], a};
    for (int k = 1; k <= 9; k++)
      w[k] = {$urandom, $urandom, $urandom, 24'($urandom), 8'(k)};
    start  = cyc;
    e.del  = 1'b0;
    e.addr = a;
    e.cyc  = 32'(start + 11 + gap + idle_low);
    e.data = {w[3][99:0], w[2], w[1]};
    e.mask = {w[6][99:0], w[5], w[4]};
    e.exec = {w[9][115:0], w[8], w[7]};
    exp_q.push_back(e);
    if (idle_low > 0) bus.dpl_idle_i = 1'b0;
    if (gap == 0) begin
      for (int k = 0; k <= 9; k++) fifo.push_back(w[k]);
      refresh();
    end else begin
      for (int k = 0; k <= 4; k++) fifo.push_back(w[k]);
      refresh();
      repeat (5) step();
      repeat (gap) step();
      for (int k = 5; k <= 9; k++) fifo.push_back(w[k]);
      refresh();
    end
    if (idle_low > 0) begin
      while (cyc < start + 10 + gap + idle_low) begin
        step();
        if (cyc >= start + 10 + gap) chk("hold_while_waiting", 512'(bus.dpl_hold_o), 512'(1));
      end
      bus.dpl_idle_i = 1'b1;
    end
    wait_done(start, 12 + gap + idle_low, "write");
    valid_exp[a] = 1'b1;
    chk("write_valid", 512'(bus.valid_o), 512'(valid_exp));
  endtask

  task automatic do_cmd(input logic [7:0] op, input logic [5:0] a);
    logic [127:0] r;
    exp_t e;
    int start;
    r = {$urandom, $urandom, $urandom, $urandom};
    start = cyc;
    e = '0;
    e.del = 1'b1;
    if (op == 8'h02) begin
      e.addr = a;
      e.cyc  = 32'(start + 2);
      exp_q.push_back(e);
    end else begin
      for (int i = 0; i < 64; i++) begin
        e.addr = 6'(i);
        e.cyc  = 32'(start + 2 + i);
        exp_q.push_back(e);
      end
    end
    fifo.push_back({op, r[119:6], a});
    refresh();
    wait_done(start, (op == 8'h02) ? 3 : 66, (op == 8'h02) ? "delete" : "clear_all");
    if (op == 8'h02) valid_exp[a] = 1'b0;
    else valid_exp = '0;
    chk("cmd_valid", 512'(bus.valid_o), 512'(valid_exp));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 512'(bus.valid_o), 512'(0));
    chk({tag, "_err"}, 512'(bus.err_o), 512'(0));
    chk({tag, "_busy"}, 512'(bus.busy_o), 512'(0));
    chk({tag, "_hold"}, 512'(bus.dpl_hold_o), 512'(0));
    chk({tag, "_prog_en"}, 512'(bus.dpl_program_enable), 512'(0));
    chk({tag, "_del_en"}, 512'(bus.dpl_delete_enable), 512'(0));
    chk({tag, "_addr"}, 512'(bus.dpl_program_addr), 512'(0));
    chk({tag, "_data"}, 512'(bus.dpl_program_data), 512'(0));
    chk({tag, "_mask"}, 512'(bus.dpl_program_mask), 512'(0));
    chk({tag, "_exec"}, 512'(bus.dpl_exec_data), 512'(0));
    chk({tag, "_cmd_rd"}, 512'(bus.cmd_rd_o), 512'(0));
    chk({tag, "_state"}, 512'(bus.fsm_state), 512'(0));
  endtask

  // scoreboard monitor: every strobe must match the head of exp_q
  always @(negedge dpl_clk) begin
    exp_t e;
    if (bus.cmd_rd_o) chk("pop_only_when_not_empty", 512'(bus.cmd_empty_i), 512'(0));
    if (bus.dpl_program_enable || bus.dpl_delete_enable) begin
      chk("strobes_exclusive", 512'(bus.dpl_program_enable & bus.dpl_delete_enable), 512'(0));
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 512'(1), 512'(0));
      end else begin
        e = exp_q.pop_front();
        chk("strobe_kind", 512'(bus.dpl_delete_enable), 512'(e.del));
        chk("strobe_addr", 512'(bus.dpl_program_addr), 512'(e.addr));
        chk("strobe_cycle", 512'(cyc), 512'(e.cyc));
        if (!e.del) begin
          chk("strobe_data", 512'(bus.dpl_program_data), 512'(e.data));
          chk("strobe_mask", 512'(bus.dpl_program_mask), 512'(e.mask));
          chk("strobe_exec", 512'(bus.dpl_exec_data), 512'(e.exec));
        end
      end
    end
  end

  initial begin
    int start;
    dpl_reset_n     = 1'b0;
    bus.dpl_idle_i  = 1'b1;
    bus.err_clr_i   = 1'b0;
    refresh();
    repeat (3) step();
    check_reset_outputs("reset");
    dpl_reset_n = 1'b1;
    repeat (2) step();

    do_write(6'd5, 0, 0);
    chk("write5_valid_bitmap", 512'(bus.valid_o), 512'(64'h20));
    do_write(6'd33, 3, 0);
    do_write(6'd5, 0, 20);
    do_cmd(8'h02, 6'd5);
    do_cmd(8'h03, 6'd0);

    // NOP consumes its word and leaves the FSM idle
    fifo.push_back({8'h00, 120'h0});
    refresh();
    step();
    chk("nop_consumed", 512'(fifo.size()), 512'(0));
    chk("nop_busy", 512'(bus.busy_o), 512'(0));
    chk("nop_err", 512'(bus.err_o), 512'(0));

    fifo.push_back({8'h7F, 120'h0});
    refresh();
    step();
    chk("bad_op_consumed", 512'(fifo.size()), 512'(0));
    chk("bad_op_err", 512'(bus.err_o), 512'(1));
    chk("bad_op_busy", 512'(bus.busy_o), 512'(0));
    bus.err_clr_i = 1'b1;
    step();
    bus.err_clr_i = 1'b0;
    chk("err_cleared", 512'(bus.err_o), 512'(0));
    fifo.push_back({8'h7F, 120'h0});
    bus.err_clr_i = 1'b1;
    refresh();
    step();
    bus.err_clr_i = 1'b0;
    chk("err_set_wins", 512'(bus.err_o), 512'(1));
    step();
    chk("err_sticky", 512'(bus.err_o), 512'(1));

    // reset lands while payload word 6 sits at the FIFO head
    start = cyc;
    fifo.push_back({8'h01, 114'h0, 6'd9});
    for (int k = 1; k <= 9; k++) fifo.push_back({$urandom, $urandom, $urandom, $urandom});
    refresh();
    while (cyc < start + 6) step();
    chk("pre_reset_busy", 512'(bus.busy_o), 512'(1));
    dpl_reset_n = 1'b0;
    #1;
    fifo.delete();
    refresh();
    check_reset_outputs("mid_reset");
    step();
    valid_exp = '0;
    dpl_reset_n = 1'b1;
    step();
    do_write(6'd2, 0, 0);
    chk("post_reset_valid", 512'(bus.valid_o), 512'(64'h4));

    repeat (3) step();
    chk("exp_q_drained", 512'(exp_q.size()), 512'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
